// File: rtl/dds_sweep_if.sv
// Configuration handshake, sweep control and DDS control-word bundle for dds_sweep_ctrl.
// master = sequencer host side, slave = dds_sweep_ctrl.
interface dds_sweep_if #(
  parameter int FREQ_WIDTH = 28,
  parameter int DAC_WIDTH  = 12,
  parameter int DIV_WIDTH  = 16
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [FREQ_WIDTH-1:0] cfg_f_start;
  logic [FREQ_WIDTH-1:0] cfg_f_step;
  logic [FREQ_WIDTH-1:0] cfg_f_stop;
  logic [DAC_WIDTH-1:0]  cfg_ampl;
  logic [DIV_WIDTH-1:0]  cfg_dwell;
  logic [DIV_WIDTH-1:0]  cfg_div;
  logic                  cfg_repeat;
  logic                  start;
  logic                  abort;
  logic [FREQ_WIDTH-1:0] Freq_KW;
  logic [DAC_WIDTH-1:0]  Ampl_KW;
  logic                  dds_ce;
  logic                  busy;
  logic                  step_strobe;
  logic                  sweep_done;

  modport master (
    output cfg_valid, cfg_f_start, cfg_f_step, cfg_f_stop, cfg_ampl,
           cfg_dwell, cfg_div, cfg_repeat, start, abort,
    input  cfg_ready, Freq_KW, Ampl_KW, dds_ce, busy, step_strobe, sweep_done
  );

  modport slave (
    input  cfg_valid, cfg_f_start, cfg_f_step, cfg_f_stop, cfg_ampl,
           cfg_dwell, cfg_div, cfg_repeat, start, abort,
    output cfg_ready, Freq_KW, Ampl_KW, dds_ce, busy, step_strobe, sweep_done
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep sequencer: captures a sweep config, generates the DDS clock enable and
// steps Freq_KW from f_start toward f_stop with a programmable dwell per step.
module dds_sweep_ctrl #(
  parameter int FREQ_WIDTH = 28,
  parameter int DAC_WIDTH  = 12,
  parameter int DIV_WIDTH  = 16
) (
  input logic        clk,
  input logic        rst_n,
  dds_sweep_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [FREQ_WIDTH-1:0] freq_q, freq_d;
  logic [DAC_WIDTH-1:0]  ampl_q, ampl_d;
  logic                  ce_q, ce_d;
  logic                  busy_q, busy_d;
  logic                  strobe_q, strobe_d;
  logic                  done_q, done_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic                  loaded_q, loaded_d;
  logic [FREQ_WIDTH-1:0] f_start_sh_q, f_start_sh_d;
  logic [FREQ_WIDTH-1:0] f_step_sh_q, f_step_sh_d;
  logic [FREQ_WIDTH-1:0] f_stop_sh_q, f_stop_sh_d;
  logic [DAC_WIDTH-1:0]  ampl_sh_q, ampl_sh_d;
  logic [DIV_WIDTH-1:0]  dwell_sh_q, dwell_sh_d;
  logic [DIV_WIDTH-1:0]  div_sh_q, div_sh_d;
  logic                  rep_sh_q, rep_sh_d;

  logic                  cfg_xfer;
  logic [FREQ_WIDTH:0]   sum;

  assign cfg_xfer = bus.cfg_valid && (state_q == IDLE);
  // One extra bit so a wrap past the top of the word is seen as overshooting f_stop.
  assign sum      = {1'b0, freq_q} + {1'b0, f_step_sh_q};

  always_comb begin
    state_d      = state_q;
    freq_d       = freq_q;
    ampl_d       = ampl_q;
    busy_d       = busy_q;
    strobe_d     = 1'b0;
    done_d       = 1'b0;
    dwell_cnt_d  = dwell_cnt_q;
    loaded_d     = loaded_q;
    f_start_sh_d = f_start_sh_q;
    f_step_sh_d  = f_step_sh_q;
    f_stop_sh_d  = f_stop_sh_q;
    ampl_sh_d    = ampl_sh_q;
    dwell_sh_d   = dwell_sh_q;
    div_sh_d     = div_sh_q;
    rep_sh_d     = rep_sh_q;
    ce_d         = (div_cnt_q == div_sh_q);
    div_cnt_d    = (div_cnt_q == div_sh_q) ? '0 : div_cnt_q + 1'b1;

    if (cfg_xfer) begin
      f_start_sh_d = bus.cfg_f_start;
      f_step_sh_d  = bus.cfg_f_step;
      f_stop_sh_d  = bus.cfg_f_stop;
      ampl_sh_d    = bus.cfg_ampl;
      dwell_sh_d   = bus.cfg_dwell;
      div_sh_d     = bus.cfg_div;
      rep_sh_d     = bus.cfg_repeat;
      loaded_d     = 1'b1;
      div_cnt_d    = '0;
    end

    if (bus.abort) begin
      state_d = IDLE;
      freq_d  = '0;
      ampl_d  = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A start landing on a config transfer is dropped so it never runs a half-loaded sweep.
          if (bus.start && loaded_q && !cfg_xfer) begin
            state_d     = RUN;
            freq_d      = f_start_sh_q;
            ampl_d      = ampl_sh_q;
            dwell_cnt_d = '0;
            busy_d      = 1'b1;
          end
        end
        RUN: begin
          if (ce_q) begin
            if (dwell_cnt_q != dwell_sh_q) begin
              dwell_cnt_d = dwell_cnt_q + 1'b1;
            end else begin
              dwell_cnt_d = '0;
              if (!sum[FREQ_WIDTH] && (sum[FREQ_WIDTH-1:0] <= f_stop_sh_q)) begin
                freq_d   = sum[FREQ_WIDTH-1:0];
                // A zero step is a constant tone, not a frequency increment.
                strobe_d = (f_step_sh_q != '0);
              end else if (rep_sh_q) begin
                freq_d = f_start_sh_q;
                done_d = 1'b1;
              end else begin
                done_d  = 1'b1;
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      freq_q       <= '0;
      ampl_q       <= '0;
      ce_q         <= 1'b0;
      busy_q       <= 1'b0;
      strobe_q     <= 1'b0;
      done_q       <= 1'b0;
      div_cnt_q    <= '0;
      dwell_cnt_q  <= '0;
      loaded_q     <= 1'b0;
      f_start_sh_q <= '0;
      f_step_sh_q  <= '0;
      f_stop_sh_q  <= '0;
      ampl_sh_q    <= '0;
      dwell_sh_q   <= '0;
      div_sh_q     <= '0;
      rep_sh_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      freq_q       <= freq_d;
      ampl_q       <= ampl_d;
      ce_q         <= ce_d;
      busy_q       <= busy_d;
      strobe_q     <= strobe_d;
      done_q       <= done_d;
      div_cnt_q    <= div_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      loaded_q     <= loaded_d;
      f_start_sh_q <= f_start_sh_d;
      f_step_sh_q  <= f_step_sh_d;
      f_stop_sh_q  <= f_stop_sh_d;
      ampl_sh_q    <= ampl_sh_d;
      dwell_sh_q   <= dwell_sh_d;
      div_sh_q     <= div_sh_d;
      rep_sh_q     <= rep_sh_d;
    end
  end

  assign bus.cfg_ready   = (state_q == IDLE);
  assign bus.Freq_KW     = freq_q;
  assign bus.Ampl_KW     = ampl_q;
  assign bus.dds_ce      = ce_q;
  assign bus.busy        = busy_q;
  assign bus.step_strobe = strobe_q;
  assign bus.sweep_done  = done_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: table of sweep configs with an event scoreboard,
// plus hand-written reset, abort, handshake and constant-tone sequences.
module tb_dds_sweep_ctrl;
  localparam int FW = 28;
  localparam int AW = 12;
  localparam int DW = 16;

  typedef struct {
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_step;
    logic [FW-1:0] f_stop;
    logic [AW-1:0] ampl;
    logic [DW-1:0] dwell;
    logic [DW-1:0] div;
    logic          rep;
    int            exp_strobes;
    logic [FW-1:0] exp_final;
  } row_t;

  typedef struct {
    logic          is_done;
    logic [FW-1:0] freq;
    logic [AW-1:0] ampl;
    int            interval;
  } evt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   t_ref = 0;
  evt_t exp_q[$];
  evt_t mon_e;
  row_t rows[6];

  dds_sweep_if #(.FREQ_WIDTH(FW), .DAC_WIDTH(AW), .DIV_WIDTH(DW)) bus ();

  dds_sweep_ctrl #(.FREQ_WIDTH(FW), .DAC_WIDTH(AW), .DIV_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every strobe or done pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && (bus.step_strobe || bus.sweep_done)) begin
      chk("strobe_done_exclusive", 32'(bus.step_strobe & bus.sweep_done), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event strobe=%0b done=%0b freq=%0h required=no_event",
                 bus.step_strobe, bus.sweep_done, bus.Freq_KW);
      end else begin
        mon_e = exp_q.pop_front();
        chk("evt_is_done", 32'(bus.sweep_done), 32'(mon_e.is_done));
        chk("evt_freq", 32'(bus.Freq_KW), 32'(mon_e.freq));
        chk("evt_ampl", 32'(bus.Ampl_KW), 32'(mon_e.ampl));
        if (mon_e.interval != 0) chk("evt_interval", 32'(cyc - t_ref), 32'(mon_e.interval));
      end
      t_ref = cyc;
    end
  end

  task automatic push_evt(input logic d, input logic [FW-1:0] f, input logic [AW-1:0] a, input int iv);
    evt_t e;
    e.is_done  = d;
    e.freq     = f;
    e.ampl     = a;
    e.interval = iv;
    exp_q.push_back(e);
  endtask

  task automatic drive_cfg(input row_t r, input logic with_start);
    @(negedge clk);
    bus.cfg_f_start = r.f_start;
    bus.cfg_f_step  = r.f_step;
    bus.cfg_f_stop  = r.f_stop;
    bus.cfg_ampl    = r.ampl;
    bus.cfg_dwell   = r.dwell;
    bus.cfg_div     = r.div;
    bus.cfg_repeat  = r.rep;
    bus.cfg_valid   = 1'b1;
    bus.start       = with_start;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t_ref = cyc;
  endtask

  task automatic abort_now();
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_row(input row_t r);
    int n;
    int per;
    int iv;
    int passes;
    chk("row_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    drive_cfg(r, 1'b0);
    if (r.div != '0) begin
      n = 0;
      @(negedge clk);
      for (int i = 0; i < 2 * (int'(r.div) + 1); i++) begin
        @(negedge clk);
        n += int'(bus.dds_ce);
      end
      chk("ce_period_count", 32'(n), 32'd2);
    end
    per    = (int'(r.dwell) + 1) * (int'(r.div) + 1);
    iv     = (r.div == '0) ? per : 0;
    passes = r.rep ? 3 : 1;
    for (int p = 0; p < passes; p++) begin
      for (int k = 1; k <= r.exp_strobes; k++) begin
        push_evt(1'b0, r.f_start + FW'(k) * r.f_step, r.ampl, iv);
        iv = per;
      end
      push_evt(1'b1, r.rep ? r.f_start : r.exp_final, r.ampl, iv);
      iv = per;
    end
    pulse_start();
    chk("start_freq", 32'(bus.Freq_KW), 32'(r.f_start));
    chk("start_ampl", 32'(bus.Ampl_KW), 32'(r.ampl));
    chk("start_busy", 32'(bus.busy), 32'd1);
    drain();
    if (!r.rep) begin
      chk("end_busy", 32'(bus.busy), 32'd0);
      chk("end_freq_hold", 32'(bus.Freq_KW), 32'(r.exp_final));
      chk("end_ampl_hold", 32'(bus.Ampl_KW), 32'(r.ampl));
      chk("end_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    end else begin
      chk("repeat_busy", 32'(bus.busy), 32'd1);
      abort_now();
      chk("repeat_abort_freq", 32'(bus.Freq_KW), 32'd0);
      chk("repeat_abort_ampl", 32'(bus.Ampl_KW), 32'd0);
      chk("repeat_abort_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    row_t r;
    rows[0] = '{28'd100, 28'd50, 28'd250, 12'h800, 16'd1, 16'd0, 1'b0, 3, 28'd250};
    rows[1] = '{28'd100, 28'd50, 28'd250, 12'h800, 16'd1, 16'd3, 1'b0, 3, 28'd250};
    rows[2] = '{28'd300, 28'd10, 28'd200, 12'h123, 16'd2, 16'd0, 1'b0, 0, 28'd300};
    rows[3] = '{28'hFFFFFF0, 28'h10, 28'hFFFFFFF, 12'hABC, 16'd1, 16'd0, 1'b1, 0, 28'hFFFFFF0};
    rows[4] = '{28'd10, 28'd5, 28'd20, 12'h7FF, 16'd0, 16'd1, 1'b1, 2, 28'd10};
    rows[5] = '{28'hFFFFF00, 28'h80, 28'hFFFFFFF, 12'h001, 16'd0, 16'd0, 1'b0, 1, 28'hFFFFF80};

    bus.cfg_valid = 1'b0; bus.cfg_f_start = '0; bus.cfg_f_step = '0; bus.cfg_f_stop = '0;
    bus.cfg_ampl = '0; bus.cfg_dwell = '0; bus.cfg_div = '0; bus.cfg_repeat = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;

    // Reset state, then ce every cycle from the second cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_freq", 32'(bus.Freq_KW), 32'd0);
    chk("rst_ampl", 32'(bus.Ampl_KW), 32'd0);
    chk("rst_ce", 32'(bus.dds_ce), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_strobes", 32'({bus.step_strobe, bus.sweep_done}), 32'd0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n += int'(bus.dds_ce);
    end
    chk("post_rst_ce_count", 32'(n), 32'd4);
    chk("post_rst_freq", 32'(bus.Freq_KW), 32'd0);

    // start with nothing loaded is ignored
    pulse_start();
    repeat (3) @(negedge clk);
    chk("unloaded_start_busy", 32'(bus.busy), 32'd0);

    // start coinciding with a config transfer is ignored; words unchanged by transfer
    drive_cfg(rows[0], 1'b1);
    repeat (3) @(negedge clk);
    chk("cfg_start_same_cycle_busy", 32'(bus.busy), 32'd0);
    chk("cfg_no_freq_change", 32'(bus.Freq_KW), 32'd0);
    chk("cfg_no_ampl_change", 32'(bus.Ampl_KW), 32'd0);

    for (int i = 0; i < 6; i++) run_row(rows[i]);

    // Constant tone: zero step never strobes and never finishes.
    r = '{28'd500, 28'd0, 28'd600, 12'h055, 16'd0, 16'd0, 1'b0, 0, 28'd500};
    drive_cfg(r, 1'b0);
    pulse_start();
    repeat (20) @(negedge clk);
    chk("tone_busy", 32'(bus.busy), 32'd1);
    chk("tone_freq", 32'(bus.Freq_KW), 32'd500);
    #1;
    abort_now();
    chk("tone_abort_busy", 32'(bus.busy), 32'd0);

    // Abort at 150, replay without reconfig, cfg ignored during RUN.
    drive_cfg(rows[0], 1'b0);
    push_evt(1'b0, 28'd150, 12'h800, 2);
    pulse_start();
    drain();
    chk("pre_abort_freq", 32'(bus.Freq_KW), 32'd150);
    abort_now();
    chk("abort_freq", 32'(bus.Freq_KW), 32'd0);
    chk("abort_ampl", 32'(bus.Ampl_KW), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    for (int rep = 0; rep < 2; rep++) begin
      push_evt(1'b0, 28'd150, 12'h800, 2);
      push_evt(1'b0, 28'd200, 12'h800, 2);
      push_evt(1'b0, 28'd250, 12'h800, 2);
      push_evt(1'b1, 28'd250, 12'h800, 2);
      pulse_start();
      chk("replay_freq", 32'(bus.Freq_KW), 32'd100);
      chk("replay_ampl", 32'(bus.Ampl_KW), 32'h800);
      if (rep == 0) begin
        @(negedge clk);
        bus.cfg_f_start = 28'd7; bus.cfg_f_step = 28'd1; bus.cfg_f_stop = 28'd9;
        bus.cfg_ampl = 12'h111; bus.cfg_valid = 1'b1;
        chk("run_cfg_ready_a", 32'(bus.cfg_ready), 32'd0);
        @(negedge clk);
        chk("run_cfg_ready_b", 32'(bus.cfg_ready), 32'd0);
        bus.cfg_valid = 1'b0;
      end
      drain();
      chk("replay_end_busy", 32'(bus.busy), 32'd0);
      chk("replay_end_freq", 32'(bus.Freq_KW), 32'd250);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Sequencer and configurator for the DDS core: drives its Freq_KW / Ampl_KW control words and a clock-enable (dds_ce) so the core runs on the system clock instead of a derived clock.
- Accepts a sweep configuration over a valid/ready handshake, then on start steps the frequency word from a start value toward a stop value, holding each step for a programmable number of ce ticks.
- Supports single-shot and repeating sweeps plus an abort that mutes the outputs.

Parameters:
FREQ_WIDTH, 28, width of the frequency control word (matches DDS Freq_KW)
DAC_WIDTH, 12, width of the amplitude control word (matches DDS Ampl_KW)
DIV_WIDTH, 16, width of the ce divider and dwell counters

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted; high only in IDLE
cfg_f_start  input  FREQ_WIDTH  sweep start frequency word
cfg_f_step  input  FREQ_WIDTH  per-step increment
cfg_f_stop  input  FREQ_WIDTH  sweep upper limit (inclusive)
cfg_ampl  input  DAC_WIDTH  amplitude word applied during sweep
cfg_dwell  input  DIV_WIDTH  ce ticks per step minus 1
cfg_div  input  DIV_WIDTH  ce period minus 1 (0 = ce every cycle)
cfg_repeat  input  1  0 = single sweep, 1 = restart at end
start  input  1  begin sweep (1-cycle pulse)
abort  input  1  stop sweep and mute
Freq_KW  output  FREQ_WIDTH  to DDS Freq_KW
Ampl_KW  output  DAC_WIDTH  to DDS Ampl_KW
dds_ce  output  1  registered clock enable for the DDS core
busy  output  1  high in RUN
step_strobe  output  1  1-cycle pulse on every frequency increment
sweep_done  output  1  1-cycle pulse when a sweep passes f_stop

Behaviour:
- The clock and reset are decided: one clock, clk; reset rst_n is synchronous and active-low. Every register is sampled only on the rising edge of clk.
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - Freq_KW, Ampl_KW, dds_ce, busy, step_strobe and sweep_done go to 0.
  - All shadow registers, div_cnt and dwell_cnt go to 0, and the loaded flag is cleared.
  - cfg_ready = (state==IDLE), so it is 1 from the first cycle after reset.
  - Reset asserted during RUN aborts immediately with the same result.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready at an edge.
  - All cfg_* fields are captured into shadow registers, loaded is set, and div_cnt is cleared.
  - Freq_KW and Ampl_KW do not change on a config transfer.
  - cfg_valid in RUN is ignored and nothing is captured.
- CE divider:
  - div_cnt counts 0..div_sh and wraps; it runs in every state.
  - dds_ce is registered: dds_ce <= (div_cnt == div_sh).
  - After reset, div_sh = 0, so dds_ce is high every cycle from the second cycle onward.
- States: IDLE, RUN.
  - IDLE → RUN: start=1, loaded=1, no abort, and no config transfer in the same cycle. A start coinciding with a config transfer is ignored and must be reissued. A start with loaded=0 is ignored.
  - On entry to RUN: Freq_KW <= f_start_sh, Ampl_KW <= ampl_sh, dwell_cnt <= 0, busy <= 1. The new outputs are visible on the cycle after start.
  - RUN, per dds_ce cycle:
    - If dwell_cnt != dwell_sh: dwell_cnt++.
    - Otherwise dwell_cnt <= 0 and a step is evaluated with sum = Freq_KW + f_step_sh, computed FREQ_WIDTH+1 bits wide.
    - If sum <= f_stop_sh and there is no carry: Freq_KW <= sum and step_strobe pulses.
    - Else, with cfg_repeat=1: Freq_KW <= f_start_sh, sweep_done pulses, and state stays RUN.
    - Else, with cfg_repeat=0: sweep_done pulses, state → IDLE, busy <= 0, and Freq_KW / Ampl_KW hold their last values.
  - Non-ce cycles in RUN: no change to counters or words.
  - abort=1 at an edge in any state: state → IDLE, Freq_KW <= 0, Ampl_KW <= 0, busy <= 0, no strobes. abort has priority over start and over a step. The loaded config is retained.
- Boundary cases:
  - f_step = 0 with f_start <= f_stop: constant tone; no strobes are ever generated.
  - f_start > f_stop: the first step evaluation gives sweep_done.
  - Carry out of FREQ_WIDTH counts as exceeding f_stop.
  - step_strobe and sweep_done are never high in the same cycle.
- Latency: start → Freq_KW updated is 1 cycle. First step occurs after (dwell+1) ce ticks.

Test Plan:
- Reset release → all outputs 0 for one cycle, then dds_ce=1 every cycle; cfg_ready=1; Freq_KW=0.
- Config start=100, step=50, stop=250, ampl=0x800, dwell=1, div=0, repeat=0, then start → Freq_KW sequence 100,150,200,250, each held 2 cycles. step_strobe ×3, then sweep_done ×1; busy falls and Freq_KW stays at 250.
- Same config with div=3 → dds_ce period 4 cycles; each Freq_KW value held 8 cycles.
- repeat=1, start=0xFFFFFF0, step=0x10, stop=0xFFFFFFF → carry detected at the first step: sweep_done, Freq_KW back to 0xFFFFFF0, busy stays 1.
- abort mid-sweep at Freq_KW=150 → next cycle Freq_KW=0, Ampl_KW=0, busy=0. A following start with no new config replays from 100.
- cfg_valid during RUN → cfg_ready=0 and no capture. start in the same cycle as a config transfer → ignored, state stays IDLE. start with no config loaded → ignored.
